// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and the
// transmitter state encoding, common to uart_transmitter and uart_receiver.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 32;
  localparam int DEF_CNT_W        = 6;
  localparam int FRAME_BITS       = 11;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity bit: makes the total count of ones in data+parity even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses bit_tick_o on the last cycle of every bit and
// wraps to zero. A synchronous clear holds it at the start of a bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::DEF_CLKS_PER_BIT,
  parameter int CNT_W        = uart_pkg::DEF_CNT_W
) (
  input  logic clk,
  input  logic clr,
  input  logic sync_clr_i,
  output logic bit_tick_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = !sync_clr_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (sync_clr_i || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Byte-at-a-time UART transmitter: REQ/ACK intake, 11-bit frame
// (start, 8 data LSB-first, even parity, stop), fully registered outputs.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 XMIT_REQ,
  input  logic [DATA_BITS-1:0] XMIT_Data,
  output logic                 XMIT_ACK,
  output logic                 XMIT_BUSY,
  output logic                 TXD,
  output tx_state_e            state_o
);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 parity_q, parity_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 txd_q, txd_d;
  logic                 bit_tick;
  logic                 accept;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk       (clk),
    .clr       (clr),
    .sync_clr_i(state_q == IDLE),
    .bit_tick_o(bit_tick)
  );

  // valid/ready contract: a byte is taken only in IDLE while REQ is high and
  // ACK is low; ACK then holds until REQ is sampled low, so a held REQ never resends.
  assign accept = (state_q == IDLE) && XMIT_REQ && !ack_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                       state_d = START;
      START:   if (bit_tick)                     state_d = DATA;
      DATA:    if (bit_tick && (idx_q == 3'd7))  state_d = PARITY;
      PARITY:  if (bit_tick)                     state_d = STOP;
      STOP:    if (bit_tick)                     state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    if (accept) begin
      shift_d  = XMIT_Data;
      parity_d = even_parity(XMIT_Data);
      idx_d    = 3'd0;
    end else if ((state_q == DATA) && bit_tick) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + 3'd1;
    end
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency to the line.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != IDLE);
    ack_d  = ack_q ? XMIT_REQ : accept;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      txd_q    <= txd_d;
    end
  end

  assign XMIT_ACK  = ack_q;
  assign XMIT_BUSY = busy_q;
  assign TXD       = txd_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: frame-position model, serial receiver with
// byte scoreboard, and directed frames with hand-computed line patterns.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int CPB = DEF_CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       clr;
  logic       XMIT_REQ;
  logic [7:0] XMIT_Data;
  logic       XMIT_ACK;
  logic       XMIT_BUSY;
  logic       TXD;
  tx_state_e  state_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int e_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_err = 0;

  uart_transmitter dut (
    .clk      (clk),
    .clr      (clr),
    .XMIT_REQ (XMIT_REQ),
    .XMIT_Data(XMIT_Data),
    .XMIT_ACK (XMIT_ACK),
    .XMIT_BUSY(XMIT_BUSY),
    .TXD      (TXD),
    .state_o  (state_o)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: position within the frame in cycles since acceptance.
  logic        m_busy, m_ack, m_txd;
  int          m_n;
  logic [10:0] m_frame;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_busy <= 1'b0;
      m_ack  <= 1'b0;
      m_txd  <= 1'b1;
      m_n    <= 0;
    end else begin
      if (m_ack && !XMIT_REQ) m_ack <= 1'b0;
      if (m_busy) begin
        if (m_n + 1 == FRAME_BITS * CPB) begin
          m_busy <= 1'b0;
          m_txd  <= 1'b1;
        end else begin
          m_txd <= m_frame[(m_n + 1) / CPB];
        end
        m_n <= m_n + 1;
      end else if (XMIT_REQ && !m_ack) begin
        m_ack   <= 1'b1;
        m_busy  <= 1'b1;
        m_n     <= 0;
        m_frame <= {1'b1, ^XMIT_Data, XMIT_Data, 1'b0};
        m_txd   <= 1'b0;
      end
    end
  end

  function automatic tx_state_e model_state();
    int b;
    if (!m_busy) return IDLE;
    b = m_n / CPB;
    if (b == 0) return START;
    if (b <= 8) return DATA;
    if (b == 9) return PARITY;
    return STOP;
  endfunction

  // compare process
  always @(posedge clk) begin
    #1;
    check("txd", 32'(TXD), 32'(m_txd));
    check("ack", 32'(XMIT_ACK), 32'(m_ack));
    check("busy", 32'(XMIT_BUSY), 32'(m_busy));
    check("state", 32'(state_o), 32'(model_state()));
  end

  // Serial receiver: samples mid-bit, pushes good bytes to rx_q.
  logic        rx_active;
  int          rx_pos;
  logic [10:0] rx_f;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_active <= 1'b0;
      rx_pos    <= 0;
    end else if (!rx_active) begin
      if (TXD == 1'b0) begin
        rx_active <= 1'b1;
        rx_pos    <= 1;
      end
    end else begin
      if (rx_pos == 10 * CPB + CPB / 2) begin
        rx_active <= 1'b0;
        if (rx_f[0] == 1'b0 && TXD == 1'b1 && (^rx_f[9:1]) == 1'b0)
          rx_q.push_back(rx_f[8:1]);
        else
          rx_err++;
      end else begin
        if (rx_pos % CPB == CPB / 2) rx_f[rx_pos / CPB] <= TXD;
        rx_pos <= rx_pos + 1;
      end
    end
  end

  // driver tasks
  task automatic wait_ack(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!XMIT_ACK && n < budget);
    check("ack_rise", 32'(XMIT_ACK), 32'd1);
    e_cyc = cyc;
  endtask

  task automatic wait_busy_low(input int budget);
    int n = 0;
    while (XMIT_BUSY && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_fall", 32'(XMIT_BUSY), 32'd0);
  endtask

  // Called at acceptance edge + 1 time unit; samples each bit mid-period.
  task automatic capture(input logic chk_ack_fall, output logic [10:0] f);
    @(posedge clk); #1;
    if (chk_ack_fall) check("ack_fall", 32'(XMIT_ACK), 32'd0);
    repeat (CPB / 2 - 1) @(posedge clk);
    #1 f[0] = TXD;
    for (int b = 1; b < FRAME_BITS; b++) begin
      repeat (CPB) @(posedge clk);
      #1 f[b] = TXD;
    end
  endtask

  initial begin
    logic [10:0] f;
    int t1;
    clr       = 1'b0;
    XMIT_REQ  = 1'b0;
    XMIT_Data = 8'h00;

    // reset
    repeat (5) @(posedge clk);
    #1;
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_ack", 32'(XMIT_ACK), 32'd0);
    check("rst_busy", 32'(XMIT_BUSY), 32'd0);
    @(negedge clk) clr = 1'b1;
    repeat (3) @(posedge clk);

    // 'T' with frame length
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'h54;
    wait_ack(50);
    XMIT_REQ = 1'b0;
    exp_q.push_back(8'h54);
    capture(1'b1, f);
    check("frame_54", 32'(f), 32'(11'b1_1_01010100_0));
    wait_busy_low(100);
    check("busy_len", 32'(cyc - e_cyc), 32'd352);

    // 'Z'
    repeat (4) @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'h5A;
    wait_ack(50);
    XMIT_REQ = 1'b0;
    exp_q.push_back(8'h5A);
    capture(1'b1, f);
    check("frame_5a", 32'(f), 32'(11'b1_0_01011010_0));
    wait_busy_low(100);

    // back-to-back: second request raised mid-DATA of the first
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'h33;
    wait_ack(50);
    XMIT_REQ = 1'b0;
    exp_q.push_back(8'h33);
    repeat (100) @(posedge clk);
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'h01;
    repeat (20) @(posedge clk);
    #1 check("ack_pending", 32'(XMIT_ACK), 32'd0);
    wait_busy_low(400);
    t1 = cyc;
    wait_ack(50);
    check("b2b_gap", 32'(cyc - t1), 32'd1);
    XMIT_REQ = 1'b0;
    exp_q.push_back(8'h01);
    capture(1'b1, f);
    check("frame_01", 32'(f), 32'(11'b1_1_00000001_0));
    wait_busy_low(100);

    // REQ held high for 1000 cycles: one frame only
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'hFF;
    wait_ack(50);
    exp_q.push_back(8'hFF);
    capture(1'b0, f);
    check("frame_ff", 32'(f), 32'(11'b1_0_11111111_0));
    repeat (1000 - 340) @(posedge clk);
    #1;
    check("ack_held", 32'(XMIT_ACK), 32'd1);
    check("no_resend", 32'(XMIT_BUSY), 32'd0);
    @(negedge clk) XMIT_REQ = 1'b0;
    @(posedge clk); #1;
    check("ack_fall_hold", 32'(XMIT_ACK), 32'd0);

    // data change right after ACK
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'hA5;
    wait_ack(50);
    XMIT_Data = 8'h00;
    XMIT_REQ  = 1'b0;
    exp_q.push_back(8'hA5);
    capture(1'b1, f);
    check("frame_a5", 32'(f), 32'(11'b1_0_10100101_0));
    wait_busy_low(100);

    // asynchronous reset mid-DATA (bit 2 of 0xC3 is 0 on the line)
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'hC3;
    wait_ack(50);
    XMIT_REQ = 1'b0;
    repeat (100) @(posedge clk);
    #4 check("pre_rst_txd", 32'(TXD), 32'd0);
    #1 clr = 1'b0;
    #1;
    check("mid_rst_txd", 32'(TXD), 32'd1);
    check("mid_rst_busy", 32'(XMIT_BUSY), 32'd0);
    check("mid_rst_ack", 32'(XMIT_ACK), 32'd0);
    check("mid_rst_state", 32'(state_o), 32'(IDLE));
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("no_resume", 32'(XMIT_BUSY), 32'd0);

    // clean frame after reset
    @(negedge clk);
    XMIT_REQ = 1'b1; XMIT_Data = 8'h96;
    wait_ack(50);
    XMIT_REQ = 1'b0;
    exp_q.push_back(8'h96);
    capture(1'b1, f);
    check("frame_96", 32'(f), 32'(11'b1_0_10010110_0));
    wait_busy_low(100);
    repeat (40) @(posedge clk);

    // scoreboard
    check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check("rx_byte", 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    check("rx_frame_err", 32'(rx_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage feeding the line that `uart_receiver` samples. It accepts one byte at a time from a producer over a four-phase REQ/ACK handshake. It serialises the byte as an 11-bit frame: start, 8 data bits LSB-first, even parity, stop. Bit timing is fixed at CLKS_PER_BIT clock cycles per bit, matching the receiver's bit period.

## Interface
- CLKS_PER_BIT, 32, clock cycles per serial bit; must be ≥ 2.
- CNT_W, 6, width of the baud counter; must satisfy 2^CNT_W ≥ CLKS_PER_BIT.
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-low.
- XMIT_REQ  input  1  producer request; XMIT_Data is valid while high.
- XMIT_Data  input  8  byte to send.
- XMIT_ACK  output  1  byte latched; stays high until XMIT_REQ is seen low.
- XMIT_BUSY  output  1  frame in progress.
- TXD  output  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TXD=1. If XMIT_REQ=1 and XMIT_ACK=0, then in that edge:
  - latch XMIT_Data into the shift register;
  - compute parity = XOR of the 8 bits;
  - set XMIT_ACK=1 and XMIT_BUSY=1;
  - clear the baud counter and go to START.
- START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: TXD=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - Bit index 0..7; after bit 7, go to PARITY.
- PARITY: TXD=parity bit (even parity; total ones in data+parity is even) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: TXD=1 for CLKS_PER_BIT cycles. On the last cycle, clear XMIT_BUSY and go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. The terminal count advances the bit/state and wraps the counter to 0.
- Handshake is independent of frame progress:
  - XMIT_ACK falls on the first edge where XMIT_REQ=0 is sampled.
  - XMIT_ACK never rises again until that has happened.
  - A producer that holds REQ high cannot cause a duplicate send.
- Data is captured only at acceptance; XMIT_Data may change once ACK is high.
- A REQ that rises while BUSY=1 is held pending (ACK stays 0). It is accepted in the first IDLE cycle.
- XMIT_REQ dropping before ACK rises is a protocol violation; no send is guaranteed.
- Reset (clr=0), asynchronous, at any time including mid-frame:
  - state=IDLE, TXD=1, XMIT_ACK=0, XMIT_BUSY=0;
  - counters and shift register cleared;
  - the partial frame is abandoned and no resume occurs.

## Timing
- Reset values: TXD=1, XMIT_ACK=0, XMIT_BUSY=0.
- Acceptance edge E: XMIT_ACK, XMIT_BUSY and TXD=0 are all visible after E. The start bit occupies cycles E+1..E+CLKS_PER_BIT.
- Data bit k occupies CLKS_PER_BIT cycles starting at E+1+(k+1)·CLKS_PER_BIT.
- Frame length: exactly 11·CLKS_PER_BIT cycles of TXD activity. XMIT_BUSY falls after edge E+11·CLKS_PER_BIT.
- Back-to-back: with REQ pending, the next acceptance edge is E+11·CLKS_PER_BIT+1. This gives exactly one extra idle-high cycle between frames.
- XMIT_ACK falls one edge after XMIT_REQ is sampled low; minimum ACK high time is 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package uart_pkg holds:
  - the state enumeration (IDLE..STOP, 3-bit encoding);
  - FRAME_BITS=11;
  - default CLKS_PER_BIT=32, shared with uart_receiver so both ends agree.
- One natural sub-module, uart_baud_gen:
  - inputs: clk, clr, sync clear;
  - output: one-cycle bit_tick at terminal count;
  - parameterised by CLKS_PER_BIT/CNT_W;
  - reusable by the receiver.
- Remaining logic (FSM, shift register, bit index, parity, handshake flop) lives in uart_transmitter.

## Test plan
- Reset: hold clr=0 for 5 cycles → TXD=1, XMIT_ACK=0, XMIT_BUSY=0. Assert clr=0 mid-DATA → TXD=1 immediately (before the next edge), state IDLE.
- Send 0x54 ('T') → TXD sequence 0, 0,0,1,0,1,0,1,0, parity 1, stop 1. Each bit lasts 32 cycles; BUSY high for 352 cycles.
- Send 0x5A ('Z') → data 0,1,0,1,1,0,1,0, parity 0. Loop TXD into uart_receiver with matching frame format and CLKS_PER_BIT → RCV_Data=0x5A.
- Handshake: hold XMIT_REQ high for 1000 cycles with 0xFF → exactly one frame sent (parity 0). ACK falls one cycle after REQ drops.
- Back-to-back: raise REQ with 0x01 during the previous frame's DATA phase → ACK stays 0 until IDLE. Exactly one idle-high cycle separates the stop bit from the next start bit.
- Data change after ACK: change XMIT_Data to 0x00 the cycle after ACK rises with 0xA5 → serialised byte is 0xA5, parity 0.
